// File: rtl/alu_pkg.sv
// alu_pkg: shared types and op-classification helpers for the alu_seq execute unit.
//   alu_op_e    4-bit op code (base integer ops plus RV32M-style mul/div)
//   alu_state_e control FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_XOR  = 4'h2, OP_OR   = 4'h3,
    OP_AND  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SRA  = 4'h7,
    OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_MUL  = 4'hA, OP_MULH = 4'hB,
    OP_DIV  = 4'hC, OP_DIVU = 4'hD, OP_REM  = 4'hE, OP_REMU = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Ops whose operands are treated as two's complement and iterated on magnitudes.
  // MUL is excluded: the low half of the product is sign-agnostic.
  function automatic logic is_signed_md(input alu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiplier / restoring divider.
//   clk, reset   clock, synchronous active-high reset
//   kill_i       abandon the current operation
//   start_i      load a_i/b_i and begin XLEN iterations
//   is_div_i     1: divide a_i by b_i, 0: multiply
//   done_o       high in the cycle whose edge performs the last iteration
//   hi_o, lo_o   accumulator value after this edge's iteration
//                (mul: product hi/lo; div: remainder/quotient)
// One 2*XLEN accumulator serves both: for multiply the low half holds the
// shrinking multiplier, for divide it holds the dividend shifting into the
// remainder while quotient bits shift in at the bottom.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc_q, acc_d, step;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d, div_q;
  logic [XLEN:0]     msum;
  logic [XLEN+1:0]   dtrial;

  always_comb begin
    // multiply: add multiplicand into upper half when multiplier LSB set, shift right
    msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, b_q});
    // divide: trial-subtract divisor from the left-shifted partial remainder
    dtrial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, b_q};
    if (div_q)
      step = dtrial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                            : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step = {msum, acc_q[XLEN-1:1]};

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_o = 1'b0;
    if (kill_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN - 1)) begin
        done_o = 1'b1;
        run_d  = 1'b0;
        cnt_d  = '0;
      end
    end
    hi_o = acc_d[2*XLEN-1:XLEN];
    lo_o = acc_d[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      if (start_i && !kill_i) begin
        b_q   <= b_i;
        div_q <= is_div_i;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute unit with valid/ready handshakes.
//   clk, reset            clock, synchronous active-high reset
//   flush                 abort current op and drop any pending result
//   in_valid/in_ready     operand handshake (ready only in IDLE)
//   rs1, rs2, ALUControl  operands and op code (alu_op_e)
//   out_valid/out_ready   result handshake; result held while out_valid
//   ALUOut, Zero, Negative registered result and flags
//   busy                  iterative mul/div in progress
// Base ops, div-by-zero, signed-overflow and (MULDIV=0) M-ops resolve in the
// accept cycle; other M-ops run XLEN iterations in alu_muldiv_iter on operand
// magnitudes, with the sign applied in the final cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      ALUControl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUOut,
  output logic            Zero,
  output logic            Negative,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e        state_q, state_d;
  alu_op_e           op_in, op_q;
  logic [XLEN-1:0]   res_q, res_d, base_res, fast_res, md_res;
  logic [XLEN-1:0]   a_mag, b_mag, md_hi, md_lo;
  logic [2*XLEN-1:0] prod_neg;
  logic [SW-1:0]     shamt;
  logic              zero_q, s1_q, s2_q, s1, s2;
  logic              accept, fast, div_zero, div_ovf, md_done;

  assign op_in  = alu_op_e'(ALUControl);
  assign accept = in_valid && (state_q == IDLE) && !flush;

  // Single-cycle datapath
  always_comb begin
    shamt = rs2[SW-1:0];
    case (op_in)
      OP_ADD:  base_res = rs1 + rs2;
      OP_SUB:  base_res = rs1 - rs2;
      OP_XOR:  base_res = rs1 ^ rs2;
      OP_OR:   base_res = rs1 | rs2;
      OP_AND:  base_res = rs1 & rs2;
      OP_SLL:  base_res = rs1 << shamt;
      OP_SRL:  base_res = rs1 >> shamt;
      OP_SRA:  base_res = $signed(rs1) >>> shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
      default: base_res = '0;
    endcase

    div_zero = is_div(op_in) && (rs2 == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1 == MIN_V) && (rs2 == '1);

    fast_res = base_res;
    if (is_muldiv(op_in)) begin
      fast_res = '0;
      if (MULDIV) begin
        if (div_zero)     fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1;
        else if (div_ovf) fast_res = (op_in == OP_DIV) ? MIN_V : '0;
      end
    end
    fast = !is_muldiv(op_in) || !MULDIV || div_zero || div_ovf;

    s1    = is_signed_md(op_in) && rs1[XLEN-1];
    s2    = is_signed_md(op_in) && rs2[XLEN-1];
    a_mag = s1 ? -rs1 : rs1;
    b_mag = s2 ? -rs2 : rs2;
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .reset    (reset),
    .kill_i   (flush),
    .start_i  (accept && !fast),
    .is_div_i (is_div(op_in)),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  // Sign fix-up on the final iteration; unsigned ops captured zero signs.
  always_comb begin
    prod_neg = -{md_hi, md_lo};
    case (op_q)
      OP_MULH:         md_res = (s1_q ^ s2_q) ? prod_neg[2*XLEN-1:XLEN] : md_hi;
      OP_DIV, OP_DIVU: md_res = (s1_q ^ s2_q) ? -md_lo : md_lo;
      OP_REM, OP_REMU: md_res = s1_q ? -md_hi : md_hi;
      default:         md_res = md_lo;
    endcase
  end

  // Next-state / result logic
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        if (fast) begin
          state_d = DONE;
          res_d   = fast_res;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: if (md_done) begin
        state_d = DONE;
        res_d   = md_res;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      op_q    <= OP_ADD;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= (res_d == '0);
      if (accept) begin
        op_q <= op_in;
        s1_q <= s1;
        s2_q <= s2;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign ALUOut    = res_q;
  assign Zero      = zero_q;
  assign Negative  = res_q[XLEN-1];

endmodule
